// File: rtl/core_time_tracker_if.sv
// core_time_tracker_if: dispatcher-to-tracker start handshake.
interface core_time_tracker_if #(
    parameter int TIME_WID = 16,
    parameter int CID_WID  = 2
);
    logic                start_vld;
    logic [CID_WID-1:0]  start_core;
    logic [TIME_WID-1:0] start_time;
    logic                start_ack;
    modport master (output start_vld, start_core, start_time, input start_ack);
    modport slave  (input start_vld, start_core, start_time, output start_ack);
endinterface

// File: rtl/core_time_tracker.sv
// core_time_tracker: per-core IDLE/BUSY tracking of active event timestamps with sticky error flags.
module core_time_tracker #(
    parameter int NUM_CORE = 4,
    parameter int TIME_WID = 16,
    parameter int CID_WID  = $clog2(NUM_CORE)
) (
    input  logic                         clk,
    input  logic                         rst,
    core_time_tracker_if.slave           st,
    input  logic [NUM_CORE-1:0]          finish,
    input  logic [TIME_WID-1:0]          gvt,
    output logic [TIME_WID*NUM_CORE-1:0] core_times,
    output logic [NUM_CORE-1:0]          core_vld,
    output logic                         idle_vld,
    output logic [CID_WID-1:0]           idle_core,
    output logic [CID_WID:0]             busy_cnt,
    output logic [2:0]                   err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    logic [NUM_CORE-1:0] nxt;
    logic [CID_WID:0]    cnt;
    logic                hit_busy, hit_fin, accept, reject, fin_idle, causal;
    assign hit_busy = core_vld[st.start_core] == BUSY;
    assign hit_fin  = finish[st.start_core];
    // A finish landing with a start on the same busy core frees it first.
    assign accept   = st.start_vld && (!hit_busy || hit_fin);
    assign reject   = st.start_vld && hit_busy && !hit_fin;
    assign fin_idle = |(finish & ~core_vld);
    assign causal   = accept && (st.start_time < gvt);
    always_comb begin
        nxt = core_vld;
        cnt = '0;
        for (int k = 0; k < NUM_CORE; k++) begin
            nxt[k] = (accept && st.start_core == CID_WID'(k)) ? BUSY : (finish[k] ? IDLE : core_vld[k]);
            cnt = cnt + (CID_WID+1)'(nxt[k]);
        end
    end
    always_comb begin
        idle_core = '0;
        for (int k = NUM_CORE-1; k >= 0; k--)
            if (core_vld[k] == IDLE) idle_core = CID_WID'(k);
    end
    assign idle_vld = ~&core_vld;
    always_ff @(posedge clk) begin
        if (rst) begin
            core_vld     <= '0;
            core_times   <= '0;
            busy_cnt     <= '0;
            err          <= '0;
            st.start_ack <= 1'b0;
        end else begin
            core_vld     <= nxt;
            busy_cnt     <= cnt;
            err          <= err | {causal, fin_idle, reject};
            st.start_ack <= accept;
            for (int k = 0; k < NUM_CORE; k++)
                if (accept && st.start_core == CID_WID'(k))
                    core_times[TIME_WID*k +: TIME_WID] <= st.start_time;
        end
    end
endmodule

// File: tb/tb_core_time_tracker.sv
// tb_core_time_tracker: directed vectors with hand-computed expectations.
module tb_core_time_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  finish = '0;
    logic [15:0] gvt = '0;
    logic [63:0] core_times;
    logic [3:0]  core_vld;
    logic        idle_vld;
    logic [1:0]  idle_core;
    logic [2:0]  busy_cnt;
    logic [2:0]  err;
    int n_cmp = 0;
    int n_err = 0;
    core_time_tracker_if #(.TIME_WID(16), .CID_WID(2)) st ();
    core_time_tracker dut (
        .clk(clk), .rst(rst), .st(st), .finish(finish), .gvt(gvt),
        .core_times(core_times), .core_vld(core_vld), .idle_vld(idle_vld),
        .idle_core(idle_core), .busy_cnt(busy_cnt), .err(err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic start_evt(input logic [1:0] c, input logic [15:0] t, input logic [3:0] f);
        st.start_vld = 1'b1;
        st.start_core = c;
        st.start_time = t;
        finish = f;
        step();
        st.start_vld = 1'b0;
        finish = '0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
    initial begin
        st.start_vld = 1'b0;
        st.start_core = '0;
        st.start_time = '0;
        step();
        do_reset();
        check("rst_vld", core_vld, 4'b0000);
        check("rst_times", core_times, 64'h0);
        check("rst_ack", st.start_ack, 1'b0);
        check("rst_busy", busy_cnt, 3'd0);
        check("rst_err", err, 3'b000);
        check("rst_idle_vld", idle_vld, 1'b1);
        check("rst_idle_core", idle_core, 2'd0);
        gvt = 16'h0010;
        start_evt(2'd2, 16'h0040, 4'b0000);
        check("s2_vld", core_vld, 4'b0100);
        check("s2_time", core_times[47:32], 16'h0040);
        check("s2_ack", st.start_ack, 1'b1);
        check("s2_busy", busy_cnt, 3'd1);
        check("s2_idle_core", idle_core, 2'd0);
        step();
        check("s2_ack_pulse", st.start_ack, 1'b0);
        do_reset();
        gvt = 16'h0000;
        for (int i = 0; i < 4; i++) start_evt(2'(i), 16'(i + 5), 4'b0000);
        check("full_idle_vld", idle_vld, 1'b0);
        check("full_idle_core", idle_core, 2'd0);
        check("full_busy", busy_cnt, 3'd4);
        check("full_times", core_times, 64'h0008_0007_0006_0005);
        finish = 4'b1010;
        step();
        finish = '0;
        check("fin_vld", core_vld, 4'b0101);
        check("fin_busy", busy_cnt, 3'd2);
        check("fin_idle_core", idle_core, 2'd1);
        check("fin_times_hold", core_times, 64'h0008_0007_0006_0005);
        check("fin_err", err, 3'b000);
        do_reset();
        start_evt(2'd1, 16'h0010, 4'b0000);
        start_evt(2'd1, 16'h0020, 4'b0010);
        check("ft_vld", core_vld, 4'b0010);
        check("ft_time", core_times[31:16], 16'h0020);
        check("ft_ack", st.start_ack, 1'b1);
        check("ft_err", err, 3'b000);
        check("ft_busy", busy_cnt, 3'd1);
        start_evt(2'd0, 16'h0030, 4'b0000);
        check("s0_ack", st.start_ack, 1'b1);
        start_evt(2'd0, 16'h0055, 4'b0000);
        check("rej_ack", st.start_ack, 1'b0);
        check("rej_time", core_times[15:0], 16'h0030);
        check("rej_err", err, 3'b001);
        finish = 4'b1000;
        step();
        finish = '0;
        check("fidle_err", err, 3'b011);
        check("fidle_vld", core_vld, 4'b0011);
        check("fidle_idle_core", idle_core, 2'd2);
        do_reset();
        gvt = 16'h0100;
        start_evt(2'd1, 16'h0100, 4'b0000);
        check("eq_gvt_err", err, 3'b000);
        start_evt(2'd0, 16'h00FF, 4'b0000);
        check("caus_vld", core_vld, 4'b0011);
        check("caus_ack", st.start_ack, 1'b1);
        check("caus_err", err, 3'b100);
        rst = 1'b1;
        start_evt(2'd2, 16'h0077, 4'b0001);
        rst = 1'b0;
        check("mid_rst_vld", core_vld, 4'b0000);
        check("mid_rst_times", core_times, 64'h0);
        check("mid_rst_ack", st.start_ack, 1'b0);
        check("mid_rst_busy", busy_cnt, 3'd0);
        check("mid_rst_err", err, 3'b000);
        check("mid_rst_idle", idle_vld, 1'b1);
        step();
        check("mid_rst_no_ack", st.start_ack, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/core_time_tracker.md
CORE_TIME_TRACKER -- requirements
Module: core_time_tracker

Interface
REQ-001 SHALL have parameter NUM_CORE, default 4: number of event-processing cores (power of two, >=2).
REQ-002 SHALL have parameter TIME_WID, default 16: timestamp width in bits.
REQ-003 SHALL have parameter CID_WID, default $clog2(NUM_CORE): core-id width in bits.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start_vld, input, 1: dispatcher requests an event start this cycle.
REQ-007 SHALL have port start_core, input, CID_WID: target core of the start.
REQ-008 SHALL have port start_time, input, TIME_WID: timestamp of the started event.
REQ-009 SHALL have port start_ack, output, 1: start accepted (registered, 1-cycle pulse).
REQ-010 SHALL have port finish, input, NUM_CORE: bit k pulses when core k completes its event.
REQ-011 SHALL have port gvt, input, TIME_WID: current global virtual time from the GVT monitor.
REQ-012 SHALL have port core_times, output, TIME_WID*NUM_CORE: core k's active timestamp at bits [TIME_WID*k +: TIME_WID].
REQ-013 SHALL have port core_vld, output, NUM_CORE: bit k high while core k is BUSY.
REQ-014 SHALL have port idle_vld, output, 1: at least one core is IDLE.
REQ-015 SHALL have port idle_core, output, CID_WID: lowest-index IDLE core; 0 when idle_vld=0.
REQ-016 SHALL have port busy_cnt, output, CID_WID+1: number of BUSY cores.
REQ-017 SHALL have port err, output, 3: sticky flags {causality, finish_idle, start_busy}.

Function
REQ-018 Each core SHALL hold a 2-state FSM, IDLE/BUSY; core_vld[k] SHALL equal (state==BUSY).
REQ-019 IDLE->BUSY SHALL occur at the edge where start_vld=1 and start_core=k and core k is IDLE; core_times[k] SHALL load start_time at that edge.
REQ-020 BUSY->IDLE SHALL occur at the edge where finish[k]=1 and core k is BUSY; core_times[k] SHALL hold its last value.
REQ-021 Same-cycle finish[k]=1 and start to core k while BUSY SHALL be treated as finish-then-start: core k stays BUSY, core_times[k] loads start_time, start_ack=1.
REQ-022 start_ack SHALL assert in the cycle after an accepted start, for exactly one cycle.
REQ-023 Start to a BUSY core without same-cycle finish SHALL be rejected: no state change, start_ack=0, err[0] set.
REQ-024 finish[k]=1 on an IDLE core SHALL be ignored, err[1] set.
REQ-025 An accepted start with start_time < gvt (unsigned) SHALL still be accepted and SHALL set err[2].
REQ-026 Multiple finish bits in one cycle SHALL all take effect at the same edge.
REQ-027 core_vld, core_times, busy_cnt, err SHALL be registered; idle_vld/idle_core SHALL be combinational from the registered state (valid in the cycle after any state change).
REQ-028 busy_cnt SHALL equal popcount(core_vld) at all times, range 0..NUM_CORE.
REQ-029 err bits SHALL be sticky until rst.
REQ-030 start_core SHALL be taken as an index modulo NUM_CORE (full-width decode, no out-of-range case for power-of-two NUM_CORE).

Reset
REQ-031 With rst=1 at an edge, all cores SHALL become IDLE; core_times=0, core_vld=0, start_ack=0, busy_cnt=0, err=0.
REQ-032 After reset: idle_vld=1, idle_core=0.
REQ-033 rst SHALL override same-cycle start_vld and finish; no start_ack SHALL follow a start coincident with rst.

Verification
REQ-034 Reset, then start core 2 time 0x0040, gvt=0x0010 -> next cycle core_vld=4'b0100, core_times[2]=0x0040, start_ack=1, busy_cnt=1, idle_core=0.
REQ-035 Fill cores 0..3 with times 5,6,7,8 -> idle_vld=0, busy_cnt=4; then finish=4'b1010 -> core_vld=4'b0101, busy_cnt=2, idle_core=1.
REQ-036 Core 1 BUSY time 0x10; same cycle finish[1]=1 and start core 1 time 0x20 -> core_vld[1]=1, core_times[1]=0x20, start_ack=1, err=0.
REQ-037 Start to BUSY core 0 without finish -> start_ack=0, core_times[0] unchanged, err=3'b001; finish[3] on IDLE core 3 -> err=3'b011.
REQ-038 gvt=0x0100, start core 0 time 0x00FF -> accepted, err[2]=1; assert rst mid-operation with start_vld=1 -> all outputs zero next cycle, no start_ack.
